// File: rtl/processor_scheduler.sv
// Row-processor sequencer: clears the array, feeds operands in lock-step, waits out
// the MAC latency and unloads results, repeating in passes of N_PROC rows.

package Definitions;
    typedef struct packed {
        logic       rst_processor;
        logic       push_result;
        logic       pop_a_v;
        logic [3:0] processor_number;
    } PROCESSORS_CONTROL_SIGNALS;
endpackage

// state | meaning
// IDLE  | waiting for start
// CLEAR | broadcast processor reset for the coming pass
// FEED  | pop one matrix column / vector element per unstalled cycle
// DRAIN | down-count MAC_LATENCY cycles until accumulators settle
// PUSH  | unload active processors 0..active-1 into the result FIFO
// DONE  | one-cycle completion pulse
module processor_scheduler #(
    parameter int N_PROC      = 4,
    parameter int MAC_LATENCY = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic [3:0]                            dim_i,
    input  logic [N_PROC-1:0]                     a_fifo_empty_i,
    input  logic                                  v_fifo_empty_i,
    input  logic                                  result_full_i,
    output Definitions::PROCESSORS_CONTROL_SIGNALS ctrl_o,
    output logic [3:0]                            row_base_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_PUSH, S_DONE
    } state_t;

    localparam logic [3:0] NP         = 4'(N_PROC);
    localparam logic [2:0] DRAIN_LOAD = 3'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  dim_q, dim_d;
    logic [3:0]  pass_q, pass_d;
    logic [3:0]  col_q, col_d;
    logic [3:0]  p_q, p_d;
    logic [2:0]  drain_q, drain_d;

    logic [3:0]        row_base;
    logic [4:0]        rows_left;
    logic [4:0]        active;
    logic              last_pass;
    logic [N_PROC-1:0] act_mask;
    logic              operands_ok;
    logic              pop;
    logic              push;

    // Rows still to process decide both the active width and whether this is the final pass.
    always_comb begin
        row_base  = pass_q * NP;
        rows_left = {1'b0, dim_q} - {1'b0, row_base};
        last_pass = (rows_left <= {1'b0, NP});
        active    = last_pass ? rows_left : {1'b0, NP};
        act_mask  = '0;
        for (int i = 0; i < N_PROC; i++) begin
            act_mask[i] = (5'(i) < active);
        end
        operands_ok = !v_fifo_empty_i && ((a_fifo_empty_i & act_mask) == '0);
        pop         = (state_q == S_FEED) && operands_ok;
        push        = (state_q == S_PUSH) && !result_full_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            dim_q   <= '0;
            pass_q  <= '0;
            col_q   <= '0;
            p_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            dim_q   <= dim_d;
            pass_q  <= pass_d;
            col_q   <= col_d;
            p_q     <= p_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dim_d   = dim_q;
        pass_d  = pass_q;
        col_d   = col_q;
        p_d     = p_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (dim_i != 4'd0) begin
                        dim_d   = dim_i;
                        pass_d  = '0;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                col_d   = '0;
                p_d     = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (pop) begin
                    col_d = col_q + 4'd1;
                    if (col_q == dim_q - 4'd1) begin
                        if (MAC_LATENCY == 0) begin
                            state_d = S_PUSH;
                        end else begin
                            drain_d = DRAIN_LOAD;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) state_d = S_PUSH;
                else                 drain_d = drain_q - 3'd1;
            end
            S_PUSH: begin
                if (push) begin
                    if ({1'b0, p_q} + 5'd1 == active) begin
                        if (last_pass) begin
                            state_d = S_DONE;
                        end else begin
                            pass_d  = pass_q + 4'd1;
                            state_d = S_CLEAR;
                        end
                    end else begin
                        p_d = p_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                pass_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_o = '0;
        case (state_q)
            S_CLEAR: begin
                ctrl_o.rst_processor    = 1'b1;
                ctrl_o.processor_number = 4'hF;
            end
            S_FEED: ctrl_o.pop_a_v = pop;
            S_PUSH: begin
                ctrl_o.push_result      = push;
                ctrl_o.processor_number = p_q;
            end
            default: ;
        endcase
        row_base_o = row_base;
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
    end

endmodule
